// File: rtl/ifetch_prefetch_buf_if.sv
// Fetch-side and memory-side handshake bundle for the instruction prefetch buffer.
// The slave modport is the buffer's view; master is the fetch stage / memory side.
interface ifetch_prefetch_buf_if;
  logic        i_fetch_req;
  logic [31:0] i_fetch_addr;
  logic        i_fetch_take;
  logic        o_fetch_rsp;
  logic [31:0] o_fetch_data;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_rsp;
  logic [31:0] i_mem_data;

  modport slave (
    input  i_fetch_req, i_fetch_addr, i_fetch_take, i_mem_rsp, i_mem_data,
    output o_fetch_rsp, o_fetch_data, o_mem_req, o_mem_addr
  );

  modport master (
    output i_fetch_req, i_fetch_addr, i_fetch_take, i_mem_rsp, i_mem_data,
    input  o_fetch_rsp, o_fetch_data, o_mem_req, o_mem_addr
  );
endinterface

// File: rtl/ifetch_prefetch_buf.sv
// Instruction prefetch buffer: fetches sequential words ahead of the fetch PC into a small
// {addr,data} queue, serves hits from the head, and flushes/restarts on a redirect.
module ifetch_prefetch_buf #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] RESET_ADDR = 32'h0,
  parameter logic [31:0] NOP        = 32'h00000013
) (
  input logic                  i_clk,
  input logic                  i_rst,
  ifetch_prefetch_buf_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StBusy, StDrain} state_e;

  state_e          state_q, state_d;
  logic [31:0]     addr_q [DEPTH];
  logic [31:0]     data_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q, count_after;
  logic [31:0]     pf_addr_q, pf_addr_d;
  logic [31:0]     tgt_q, tgt_d;
  logic [31:0]     mem_addr_q, mem_addr_d;

  logic        nonempty, hit, redir, push, pop;
  logic [31:0] head_addr, exp_addr;

  assign nonempty  = (count_q != '0);
  assign head_addr = addr_q[rd_ptr_q];
  assign hit       = bus.i_fetch_req & nonempty & (head_addr == bus.i_fetch_addr);
  assign exp_addr  = nonempty ? head_addr : pf_addr_q;
  assign redir     = bus.i_fetch_req & ~hit & (bus.i_fetch_addr != exp_addr);
  assign pop       = hit & bus.i_fetch_take;
  // Responses are only accepted into the queue while BUSY; DRAIN responses are discarded.
  assign push      = (state_q == StBusy) & bus.i_mem_rsp & ~redir;
  assign count_after = count_q + CntW'(push) - CntW'(pop);

  assign bus.o_fetch_rsp  = hit;
  assign bus.o_fetch_data = hit ? data_q[rd_ptr_q] : NOP;
  assign bus.o_mem_req    = (state_q == StBusy) || (state_q == StDrain);
  assign bus.o_mem_addr   = mem_addr_q;

  always_comb begin
    state_d    = state_q;
    pf_addr_d  = pf_addr_q;
    tgt_d      = tgt_q;
    mem_addr_d = mem_addr_q;
    unique case (state_q)
      StIdle: begin
        if (redir) begin
          pf_addr_d = bus.i_fetch_addr;
        end else if (count_q < DepthC) begin
          state_d    = StBusy;
          mem_addr_d = pf_addr_q;
        end
      end
      StBusy: begin
        if (redir) begin
          if (bus.i_mem_rsp) begin
            pf_addr_d = bus.i_fetch_addr;
            state_d   = StIdle;
          end else begin
            // Request must stay held until memory answers; remember where to restart.
            tgt_d   = bus.i_fetch_addr;
            state_d = StDrain;
          end
        end else if (bus.i_mem_rsp) begin
          pf_addr_d = pf_addr_q + 32'd4;
          if (count_after < DepthC) begin
            mem_addr_d = pf_addr_q + 32'd4;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StDrain: begin
        if (redir) begin
          tgt_d = bus.i_fetch_addr;
        end
        if (bus.i_mem_rsp) begin
          pf_addr_d = redir ? bus.i_fetch_addr : tgt_q;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      pf_addr_q  <= RESET_ADDR;
      tgt_q      <= RESET_ADDR;
      mem_addr_q <= RESET_ADDR;
    end else begin
      state_q    <= state_d;
      pf_addr_q  <= pf_addr_d;
      tgt_q      <= tgt_d;
      mem_addr_q <= mem_addr_d;
      if (redir) begin
        count_q  <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        count_q <= count_after;
        if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  // Queue storage needs no reset; count_q qualifies every read.
  always_ff @(posedge i_clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= pf_addr_q;
      data_q[wr_ptr_q] <= bus.i_mem_data;
    end
  end
endmodule

// File: tb/tb_ifetch_prefetch_buf.sv
// Scoreboard bench for ifetch_prefetch_buf: directed fetch streams, redirects and resets
// against a simple memory model with configurable response delay.
module tb_ifetch_prefetch_buf;
  localparam logic [31:0] NopW = 32'h00000013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ifetch_prefetch_buf_if bus ();

  ifetch_prefetch_buf #(
    .DEPTH     (4),
    .RESET_ADDR(32'h0),
    .NOP       (NopW)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_fetch_q[$];
  logic [31:0] exp_mem_q[$];
  int mem_delay = 0;
  int wait_cnt  = 0;
  bit force_rsp = 1'b0;
  int cyc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A50000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input logic [31:0] a);
    bus.i_fetch_addr = a;
    exp_fetch_q.delete();
    exp_fetch_q.push_back(mem_word(a));
  endtask

  task automatic push_mem(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) exp_mem_q.push_back(first + 32'(4 * i));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rst_mem_req"}, 32'(bus.o_mem_req), 32'd0);
    chk({tag, "_rst_mem_addr"}, bus.o_mem_addr, 32'h0);
    chk({tag, "_rst_fetch_rsp"}, 32'(bus.o_fetch_rsp), 32'd0);
    chk({tag, "_rst_fetch_data"}, bus.o_fetch_data, NopW);
  endtask

  // Consume n sequential words from the current fetch address; returns cycles used.
  task automatic run_fetch(input int n, output int cycles);
    logic [31:0] pc;
    int done;
    bit took;
    pc = bus.i_fetch_addr;
    done = 0;
    cycles = 0;
    bus.i_fetch_req  = 1'b1;
    bus.i_fetch_take = 1'b1;
    while (done < n && cycles < 100) begin
      @(negedge clk);
      took = bus.o_fetch_rsp;
      step();
      cycles++;
      if (took) begin
        done++;
        pc += 32'd4;
        set_addr(pc);
        if (done == n) bus.i_fetch_take = 1'b0;
      end
    end
    bus.i_fetch_take = 1'b0;
    chk("fetch_progress", 32'(done), 32'(n));
  endtask

  task automatic settle(input string tag);
    repeat (30) step();
    chk({tag, "_mem_idle"}, 32'(bus.o_mem_req), 32'd0);
    chk({tag, "_mem_q_drained"}, 32'(exp_mem_q.size()), 32'd0);
    exp_mem_q.delete();
  endtask

  // Memory model: answers a held request after mem_delay waiting cycles.
  initial begin
    bus.i_mem_rsp  = 1'b0;
    bus.i_mem_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (force_rsp) begin
        bus.i_mem_rsp  = 1'b1;
        bus.i_mem_data = 32'hDEADBEEF;
        force_rsp      = 1'b0;
        wait_cnt       = 0;
      end else if (bus.o_mem_req && wait_cnt >= mem_delay) begin
        bus.i_mem_rsp  = 1'b1;
        bus.i_mem_data = mem_word(bus.o_mem_addr);
        wait_cnt       = 0;
      end else begin
        bus.i_mem_rsp  = 1'b0;
        bus.i_mem_data = '0;
        wait_cnt       = bus.o_mem_req ? wait_cnt + 1 : 0;
      end
    end
  end

  // Monitor: fetch port against the expected-word queue, memory handshakes against address queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_fetch_rsp) begin
        if (exp_fetch_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fetch_unexpected: got hit data %h expected no hit", bus.o_fetch_data);
        end else begin
          chk("fetch_data", bus.o_fetch_data, exp_fetch_q[0]);
          if (bus.i_fetch_take) void'(exp_fetch_q.pop_front());
        end
      end else begin
        chk("fetch_nop", bus.o_fetch_data, NopW);
      end
      if (bus.o_mem_req && bus.i_mem_rsp) begin
        if (exp_mem_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mem_unexpected: got addr %h expected no request", bus.o_mem_addr);
        end else begin
          chk("mem_addr", bus.o_mem_addr, exp_mem_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.i_fetch_req  = 1'b1;
    bus.i_fetch_take = 1'b0;

    // Startup and fill: no take, expect exactly 4 fetches then idle with a held hit.
    mem_delay = 0;
    set_addr(32'h0);
    push_mem(32'h0, 4);
    do_reset();
    check_reset_outputs("a");
    step();
    chk("a_c1_no_hit", 32'(bus.o_fetch_rsp), 32'd0);
    chk("a_c1_mem_req", 32'(bus.o_mem_req), 32'd1);
    step();
    chk("a_first_hit", 32'(bus.o_fetch_rsp), 32'd1);
    chk("a_first_data", bus.o_fetch_data, 32'hA5A50000);
    settle("a");
    chk("a_full_hit", 32'(bus.o_fetch_rsp), 32'd1);

    // Steady stream: one word per cycle with no gaps.
    push_mem(32'h10, 12);
    run_fetch(12, cyc);
    chk("b_stream_cycles", 32'(cyc), 32'd12);
    settle("b");

    // Redirect while BUSY with slow memory: request held, old data dropped.
    mem_delay = 3;
    set_addr(32'h10);
    push_mem(32'h10, 1);
    push_mem(32'h200, 8);
    do_reset();
    step();
    step();
    chk("c_busy_addr", bus.o_mem_addr, 32'h10);
    step();
    set_addr(32'h200);
    step();
    chk("c_drain_req", 32'(bus.o_mem_req), 32'd1);
    chk("c_drain_addr", bus.o_mem_addr, 32'h10);
    run_fetch(4, cyc);
    settle("c");

    // Redirect coincident with a response: no push, restart via IDLE.
    mem_delay = 0;
    set_addr(32'h0);
    push_mem(32'h0, 1);
    push_mem(32'h300, 6);
    do_reset();
    step();
    set_addr(32'h300);
    step();
    chk("d_idle_req", 32'(bus.o_mem_req), 32'd0);
    chk("d_no_hit", 32'(bus.o_fetch_rsp), 32'd0);
    step();
    chk("d_new_req", 32'(bus.o_mem_req), 32'd1);
    chk("d_new_addr", bus.o_mem_addr, 32'h300);
    run_fetch(2, cyc);
    settle("d");

    // Reset while DRAIN; a stray response afterwards must be ignored.
    mem_delay = 3;
    set_addr(32'h40);
    do_reset();
    step();
    step();
    set_addr(32'h400);
    step();
    chk("r_drain_addr", bus.o_mem_addr, 32'h40);
    @(negedge clk);
    rst = 1'b1;
    force_rsp = 1'b1;
    step();
    check_reset_outputs("r");
    rst = 1'b0;
    set_addr(32'h0);
    push_mem(32'h0, 6);
    step();
    chk("r_no_bogus_push", 32'(bus.o_fetch_rsp), 32'd0);
    chk("r_restart_req", 32'(bus.o_mem_req), 32'd1);
    chk("r_restart_addr", bus.o_mem_addr, 32'h0);
    run_fetch(2, cyc);
    settle("r");

    // Address wrap across 32'hFFFFFFFC -> 0.
    mem_delay = 0;
    set_addr(32'hFFFFFFF8);
    push_mem(32'hFFFFFFF8, 7);
    do_reset();
    run_fetch(3, cyc);
    settle("e");
    chk("e_wrap_hit", 32'(bus.o_fetch_rsp), 32'd1);
    chk("e_wrap_data", bus.o_fetch_data, 32'hA5A50004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ifetch_prefetch_buf.md
Name: ifetch_prefetch_buf

Overview:
- Instruction prefetch buffer between the fetch stage's ibus master port and instruction memory.
- Fetches sequential words ahead of the fetch PC and holds up to DEPTH {addr,data} entries.
- Serves the fetch stage from the queue head.
- On a fetch-address mismatch (branch/jump redirect), discards the queue and any in-flight response, then restarts prefetch at the new address.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- RESET_ADDR, 32'h0, prefetch address after reset.
- NOP, 32'h00000013, data driven on o_fetch_data when not hitting.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_fetch_req  in  1  fetch stage requests the word at i_fetch_addr.
- i_fetch_addr  in  32  requested instruction address (word aligned).
- i_fetch_take  in  1  fetch stage consumes the current hit (its PC advances this cycle).
- o_fetch_rsp  out  1  head entry matches the request; data valid this cycle.
- o_fetch_data  out  32  head data on hit, else NOP.
- o_mem_req  out  1  memory read request, held until i_mem_rsp.
- o_mem_addr  out  32  memory read address, stable while o_mem_req=1.
- i_mem_rsp  in  1  memory returns data for o_mem_addr this cycle.
- i_mem_data  in  32  returned instruction word.

Behaviour:
- Reset: state=IDLE, count=0, pointers=0, pf_addr=RESET_ADDR, o_mem_req=0, o_mem_addr=RESET_ADDR, o_fetch_rsp=0, o_fetch_data=NOP. Reset mid-transaction abandons the outstanding request; any i_mem_rsp that arrives while not BUSY/DRAIN is ignored.
- Hit: hit = i_fetch_req & (count!=0) & (head_addr==i_fetch_addr), comparing the full 32 bits. Combinational: o_fetch_rsp=hit; o_fetch_data = hit ? head_data : NOP.
- Pop: on the clock edge where hit & i_fetch_take.
- Expected address: exp = (count!=0) ? head_addr : pf_addr.
- Redirect: redir = i_fetch_req & ~hit & (i_fetch_addr != exp).
  - Next edge: count<=0 and pointers reset.
  - If not in flight: pf_addr<=i_fetch_addr.
  - i_fetch_req=0 never redirects.
- Empty queue with i_fetch_addr==pf_addr: wait, o_fetch_rsp=0, no redirect.
- Memory FSM, o_mem_req=1 exactly in BUSY and DRAIN (registered).
  - IDLE:
    - if count<DEPTH and ~redir, go BUSY with o_mem_addr<=pf_addr.
    - if redir, apply it and stay IDLE one cycle.
  - BUSY, on i_mem_rsp:
    - if ~redir: push {pf_addr,i_mem_data}; pf_addr<=pf_addr+4 (32-bit wrap, FFFFFFFC->0).
    - next state: BUSY with new o_mem_addr if post-update count<DEPTH, else IDLE.
  - BUSY, redir & i_mem_rsp: discard data; pf_addr<=i_fetch_addr; go IDLE.
  - BUSY, redir & ~i_mem_rsp: tgt<=i_fetch_addr; go DRAIN. o_mem_req and o_mem_addr stay held.
  - DRAIN:
    - on i_mem_rsp: discard data; pf_addr<=tgt; go IDLE.
    - a further redir updates tgt; queue stays empty.
- Push and pop on the same edge: count unchanged. Issue is gated by count<DEPTH, so a push never meets a full queue.
- One outstanding memory request maximum. Responses are in order.
- Latency: memory rsp at edge N, o_fetch_rsp=1 in the cycle after edge N; no bypass from memory to fetch port.

Test Plan:
- Reset, then i_fetch_req=1 with addr 0x0; memory responds 1 cycle after each request with data=addr^0xA5A5_0000. Expect requests to 0x0,0x4,0x8,... with o_mem_req continuous; first o_fetch_rsp with data 0xA5A50000 the cycle after the first rsp.
- Fill: hold i_fetch_take=0 at addr 0x0. Expect exactly DEPTH=4 pushes (0x0..0xC), then o_mem_req=0. count stays 4 and o_fetch_rsp stays 1.
- Steady stream: take every cycle while memory answers every cycle. Expect o_fetch_data sequence 0x0,0x4,0x8,... with no gaps after startup, and simultaneous push/pop holding count constant.
- Redirect with rsp delayed 3 cycles: while BUSY on 0x10, change i_fetch_addr to 0x200. Expect o_mem_addr held at 0x10 until rsp and that data discarded; the next request is 0x200; first hit data = value for 0x200.
- Redirect coincident with i_mem_rsp: expect no push, next o_mem_addr=new address one cycle later via IDLE. Also issue reset while in DRAIN: expect all outputs at reset values next cycle; a late rsp is ignored.
- Wrap: redirect to 0xFFFFFFF8. Expect fetches 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 with correct hits.
